// File: rtl/pwm_multi_generator.sv
// Multi-channel PWM generator: one shared period counter, per-channel double-buffered
// duty registers updated only at the period wrap, with optional per-period duty ramping.
module pwm_multi_generator #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 16,
    parameter int PERIOD    = 24000,
    parameter int RAMP_STEP = 0
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [CHANNELS*WIDTH-1:0] Invoer,
    input  logic                      Laden,
    input  logic [CHANNELS-1:0]       Inschakelen,
    output logic [CHANNELS-1:0]       Uitvoer,
    output logic                      PeriodeEinde
);

    localparam logic [WIDTH-1:0] PERIOD_W = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] LAST_W   = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH:0]   STEP_W   = (WIDTH+1)'(RAMP_STEP);

    logic [WIDTH-1:0] cnt_p0;
    logic             wrap_p0;
    logic [WIDTH-1:0] pending_p0 [CHANNELS];
    logic [WIDTH-1:0] active_p0  [CHANNELS];
    logic [WIDTH-1:0] target     [CHANNELS];

    function automatic logic [WIDTH-1:0] clamp_duty(input logic [WIDTH-1:0] v);
        return (v > PERIOD_W) ? PERIOD_W : v;
    endfunction

    // Step toward the target by at most RAMP_STEP; one extra bit keeps the sum from wrapping.
    function automatic logic [WIDTH-1:0] ramp_duty(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] c;
        logic [WIDTH:0] t;
        logic [WIDTH:0] r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        r = t;
        if (RAMP_STEP != 0) begin
            if ((t > c) && ((t - c) > STEP_W))
                r = c + STEP_W;
            else if ((c > t) && ((c - t) > STEP_W))
                r = c - STEP_W;
        end
        return r[WIDTH-1:0];
    endfunction

    assign wrap_p0      = (cnt_p0 == LAST_W);
    assign PeriodeEinde = wrap_p0;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            target[i] = Laden ? clamp_duty(Invoer[i*WIDTH +: WIDTH]) : pending_p0[i];
        end
    end

    // Stage p0: counter, pending and active duty registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt_p0 <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                pending_p0[i] <= '0;
                active_p0[i]  <= '0;
            end
        end else begin
            cnt_p0 <= wrap_p0 ? '0 : cnt_p0 + 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                if (Laden)
                    pending_p0[i] <= clamp_duty(Invoer[i*WIDTH +: WIDTH]);
                if (wrap_p0)
                    active_p0[i] <= ramp_duty(active_p0[i], target[i]);
            end
        end
    end

    // Stage p1: registered comparator outputs, one cycle behind the counter
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Uitvoer <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                Uitvoer[i] <= Inschakelen[i] & (cnt_p0 < active_p0[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Directed bench for pwm_multi_generator: a step-at-once instance and a ramping instance
// share clock and reset; each period's output shape is captured and compared.
module tb_pwm_multi_generator;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int P  = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH*W-1:0]   inv0, inv1;
    logic              ld0, ld1;
    logic [CH-1:0]     en0, en1;
    logic [CH-1:0]     out0, out1;
    logic              pe0, pe1;

    int compared   = 0;
    int mismatched = 0;
    int ph         = 0;

    always #5 clk = ~clk;

    pwm_multi_generator #(.CHANNELS(CH), .WIDTH(W), .PERIOD(P), .RAMP_STEP(0)) dut0 (
        .CLK(clk), .Reset(rst_n), .Invoer(inv0), .Laden(ld0),
        .Inschakelen(en0), .Uitvoer(out0), .PeriodeEinde(pe0)
    );

    pwm_multi_generator #(.CHANNELS(CH), .WIDTH(W), .PERIOD(P), .RAMP_STEP(2)) dut1 (
        .CLK(clk), .Reset(rst_n), .Invoer(inv1), .Laden(ld1),
        .Inschakelen(en1), .Uitvoer(out1), .PeriodeEinde(pe1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ph = (ph + 1) % P;
    endtask

    task automatic run_to(input int p);
        while (ph != p) tick();
    endtask

    function automatic logic [P-1:0] dmask(input int d);
        logic [P-1:0] m;
        m = '0;
        for (int j = 0; j < P; j++) if (j < d) m[j] = 1'b1;
        return m;
    endfunction

    task automatic load0(input logic [CH*W-1:0] v);
        inv0 = v; ld0 = 1'b1;
        tick();
        ld0 = 1'b0;
    endtask

    task automatic load1(input logic [CH*W-1:0] v);
        inv1 = v; ld1 = 1'b1;
        tick();
        ld1 = 1'b0;
    endtask

    // One full period starting at C=0; bit j of each capture is the output for C=j.
    task automatic measure(input string tag,
                           input logic [P-1:0] e00, input logic [P-1:0] e01,
                           input logic [P-1:0] e10, input logic [P-1:0] e11,
                           input int ld_ph, input logic [CH*W-1:0] ld_val,
                           input int off_ph, input int on_ph);
        logic [P-1:0] s00, s01, s10, s11, p0, p1;
        for (int j = 0; j < P; j++) begin
            if (j == ld_ph) begin inv0 = ld_val; ld0 = 1'b1; end
            if (j == off_ph) en0 = 2'b01;
            if (j == on_ph)  en0 = 2'b11;
            tick();
            ld0 = 1'b0;
            s00[j] = out0[0]; s01[j] = out0[1];
            s10[j] = out1[0]; s11[j] = out1[1];
            p0[j]  = pe0;     p1[j]  = pe1;
        end
        check({tag, "/d0c0"}, 32'(s00), 32'(e00));
        check({tag, "/d0c1"}, 32'(s01), 32'(e01));
        check({tag, "/d1c0"}, 32'(s10), 32'(e10));
        check({tag, "/d1c1"}, 32'(s11), 32'(e11));
        check({tag, "/pe0"},  32'(p0),  32'h100);
        check({tag, "/pe1"},  32'(p1),  32'h100);
    endtask

    int r0 [5] = '{2, 4, 6, 7, 7};
    int r1 [5] = '{2, 3, 3, 3, 3};
    int f0 [3] = '{5, 3, 1};
    int f1 [3] = '{5, 7, 9};

    initial begin
        rst_n = 1'b0; ld0 = 1'b0; ld1 = 1'b0;
        inv0 = '0; inv1 = '0; en0 = 2'b11; en1 = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("rst/out0", 32'(out0), 32'h0);
        check("rst/out1", 32'(out1), 32'h0);
        check("rst/pe0",  32'(pe0),  32'h0);
        check("rst/pe1",  32'(pe1),  32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; ph = 0;
        measure("idle", dmask(0), dmask(0), dmask(0), dmask(0), -1, '0, -1, -1);

        load0({8'd7, 8'd3});
        run_to(0);
        measure("d3_7a", dmask(3), dmask(7), dmask(0), dmask(0), -1, '0, -1, -1);
        measure("d3_7b", dmask(3), dmask(7), dmask(0), dmask(0), -1, '0, -1, -1);

        load0({8'd10, 8'd0});
        run_to(0);
        measure("d0_10a", dmask(0), dmask(10), dmask(0), dmask(0), -1, '0, -1, -1);
        measure("d0_10b", dmask(0), dmask(10), dmask(0), dmask(0), -1, '0, -1, -1);
        load0({8'd10, 8'd15});
        run_to(0);
        measure("clamp", dmask(10), dmask(10), dmask(0), dmask(0), -1, '0, -1, -1);

        load0({8'd7, 8'd3});
        run_to(0);
        measure("midld", dmask(3), dmask(7), dmask(0), dmask(0), 4, {8'd7, 8'd8}, -1, -1);
        measure("wrapld", dmask(8), dmask(7), dmask(0), dmask(0), 9, {8'd7, 8'd5}, -1, -1);
        measure("after_wrapld", dmask(5), dmask(7), dmask(0), dmask(0), -1, '0, -1, -1);

        load1({8'd3, 8'd7});
        run_to(0);
        for (int k = 0; k < 5; k++)
            measure($sformatf("rampup%0d", k), dmask(5), dmask(7), dmask(r0[k]), dmask(r1[k]),
                    -1, '0, -1, -1);
        load1({8'd9, 8'd1});
        run_to(0);
        for (int k = 0; k < 3; k++)
            measure($sformatf("rampdn%0d", k), dmask(5), dmask(7), dmask(f0[k]), dmask(f1[k]),
                    -1, '0, -1, -1);

        load0({8'd8, 8'd5});
        run_to(0);
        measure("en_base", dmask(5), dmask(8), dmask(1), dmask(9), -1, '0, -1, -1);
        measure("en_gap", dmask(5), 10'h0E3, dmask(1), dmask(9), -1, '0, 2, 5);

        run_to(9);
        check("prerst/pe0",  32'(pe0),  32'h1);
        check("prerst/out1", 32'(out1), 32'h2);
        rst_n = 1'b0;
        #1;
        check("asyncrst/out0", 32'(out0), 32'h0);
        check("asyncrst/out1", 32'(out1), 32'h0);
        check("asyncrst/pe0",  32'(pe0),  32'h0);
        check("asyncrst/pe1",  32'(pe1),  32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; ph = 0;
        measure("postrst", dmask(0), dmask(0), dmask(0), dmask(0), -1, '0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
